// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the default-slave response state encoding.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_WAIT_ENC = 2'd1;
  localparam logic [1:0] ST_ERR1_ENC = 2'd2;
  localparam logic [1:0] ST_ERR2_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_ERR1 = ST_ERR1_ENC,
    ST_ERR2 = ST_ERR2_ENC
  } state_e;

  // NONSEQ and SEQ carry data; IDLE and BUSY never need a real response.
  function automatic logic htrans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: htrans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  htrans_active = 1'b0;
      default:                   htrans_active = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahblite_err_logger.sv
// Records the address/direction of each default-slave hit, counts hits
// (saturating) and raises a one-cycle interrupt pulse per hit.
module ahblite_err_logger #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              accept,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              fault_write,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_irq
);

  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic              fault_write_q, fault_write_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              err_irq_q, err_irq_d;

  always_comb begin
    fault_addr_d  = fault_addr_q;
    fault_write_d = fault_write_q;
    err_count_d   = err_count_q;
    err_irq_d     = accept;
    if (accept) begin
      fault_addr_d  = haddr;
      fault_write_d = hwrite;
    end
    // A clear that coincides with a hit still records that hit.
    if (err_clr) begin
      err_count_d = accept ? CNT_W'(1) : '0;
    end else if (accept && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      fault_addr_q  <= '0;
      fault_write_q <= 1'b0;
      err_count_q   <= '0;
      err_irq_q     <= 1'b0;
    end else begin
      fault_addr_q  <= fault_addr_d;
      fault_write_q <= fault_write_d;
      err_count_q   <= err_count_d;
      err_irq_q     <= err_irq_d;
    end
  end

  assign fault_addr  = fault_addr_q;
  assign fault_write = fault_write_q;
  assign err_count   = err_count_q;
  assign err_irq     = err_irq_q;

endmodule

// File: rtl/ahblite_default_slave_ctrl.sv
// AHB-Lite default slave: programmable wait states followed by a two-cycle
// ERROR or a zero-data OKAY, with hit logging in ahblite_err_logger.
module ahblite_default_slave_ctrl
  import ahblite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int RESP_MODE   = 0,
  parameter int CNT_W       = 8
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              fault_write,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_irq,
  input  logic              err_clr
);

  localparam logic       HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic       ERR_MODE  = (RESP_MODE == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       hreadyout_q, hreadyout_d;
  logic       hresp_q, hresp_d;
  logic       accept;

  // Handshake: an address phase is taken when HSEL and an active HTRANS are
  // presented while HREADY is high; the data phase completes on the first
  // cycle HREADYOUT is high. Only a ready slave can take a new address, so
  // stray requests during WAIT/ERR1 are dropped here rather than logged.
  always_comb begin
    accept     = HSEL & htrans_active(HTRANS) & HREADY & hreadyout_q;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (HAS_WAIT) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else if (ERR_MODE) begin
            state_d = ST_ERR1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ERR_MODE ? ST_ERR1 : ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = '0;

  ahblite_err_logger #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_logger (
    .HCLK       (HCLK),
    .HRESETN    (HRESETN),
    .accept     (accept),
    .haddr      (HADDR),
    .hwrite     (HWRITE),
    .err_clr    (err_clr),
    .fault_addr (fault_addr),
    .fault_write(fault_write),
    .err_count  (err_count),
    .err_irq    (err_irq)
  );

endmodule
